pc_sequencer: RTL
=================

// Module: pc_sequencer
// PURPOSE
//  Control-side partner of the PC: fetches an instruction at the current PC, decodes it and drives
//  the PC's cntrl/loadIn port for exactly one cycle per instruction (00 hold, 01 load, 10 +1, 11 +2).
//  Sits between the PC and instruction memory; the PC's registered output feeds back as pc.
//  Shares clk/clr with the PC, so both reset together.
// PARAMETERS
//  ADDR_W   4   PC / address / loadIn width
//  INSTR_W  8   instruction width; opcode = [INSTR_W-1:INSTR_W-4], operand = [ADDR_W-1:0]
//  TIMEOUT  15  fetch-wait limit in cycles (used only with PCSEQ_FETCH_TIMEOUT_EN)
// PORTS
//  clk        in   1        rising-edge clock
//  clr        in   1        asynchronous active-low reset
//  start      in   1        begin execution; sampled only in IDLE
//  pc         in   ADDR_W   current PC value (PC module out)
//  zflag      in   1        zero flag for BZ
//  imem_req   out  1        fetch request; imem_addr valid while high
//  imem_addr  out  ADDR_W   fetch address (= pc)
//  imem_ack   in   1        memory has imem_data valid this cycle
//  imem_data  in   INSTR_W  fetched instruction
//  cntrl      out  2        PC control: 00 hold, 01 load, 10 +1, 11 +2
//  loadIn     out  ADDR_W   PC load value, meaningful when cntrl=01
//  busy       out  1        high in FETCH/UPD
//  halted     out  1        high in HALTED
//  err        out  1        fetch timeout (0 when macro off)
// BEHAVIOUR
//  - All outputs registered. clr low: state=IDLE, imem_req=0, cntrl=00, loadIn=0, busy=0,
//    halted=0, err=0, IR=0, timeout counter=0; takes effect immediately, including mid-fetch.
//  - States: IDLE, FETCH, UPD, HALTED.
//  - IDLE: cntrl=00. start=1 on an edge -> FETCH. start is ignored in all other states.
//  - FETCH: imem_req=1, imem_addr=pc, cntrl=00. On an edge with imem_ack=1: IR<=imem_data,
//    Z<=zflag (both sampled on this same edge), imem_req<=0 -> UPD. No ack -> remain in FETCH.
//    Ack is accepted in the cycle after req rises at the earliest, so 0-wait memory gives
//    2 cycles per instruction.
//  - UPD (exactly 1 cycle): cntrl/loadIn driven per IR. The PC updates on the edge ending UPD.
//    Next state is FETCH, except for HALT.
//    op 0 NOP  -> 10
//    op 1 JMP  -> 01, loadIn=operand
//    op 2 SKIP -> 11
//    op 3 BZ   -> Z ? 01 (loadIn=operand) : 10
//    op 4 SPIN -> 00; refetches the same address, which polls memory/zflag
//    op F HALT -> 00 -> HALTED
//    any other op -> treated as NOP (10)
//  - HALTED: cntrl=00, imem_req=0, halted=1. Left only by clr.
//  - Wrap-around belongs to the PC (mod 2^ADDR_W); the sequencer does no PC arithmetic.
//  - imem_ack outside FETCH is ignored. imem_data is don't-care when ack=0.
//  - loadIn holds its last value when cntrl!=01; it is 0 after reset.
// CONFIGURATION
//  PCSEQ_FETCH_TIMEOUT_EN defined:
//    - Counter clears on FETCH entry and increments each FETCH cycle without ack.
//    - On reaching TIMEOUT: imem_req<=0, err<=1, -> HALTED.
//    - An ack on the same edge the count reaches TIMEOUT wins: normal capture, no error.
//  Undefined:
//    - No counter; FETCH waits indefinitely.
//    - err is held at 0.
// TESTING
//  1. clr pulse, start=1, memory all 0x00 with 0-wait ack -> cntrl=10 once every 2 cycles;
//     fetch addresses 0,1,...,15,0 (wrap).
//  2. mem[0]=0x1A -> in UPD cntrl=01, loadIn=A; next imem_addr=A.
//  3. mem[14]=0x20 -> cntrl=11; next fetch addr=0.
//  4. mem[0]=0x35: zflag=1 at ack -> load, next addr=5; zflag=0 -> +1, next addr=1.
//  5. mem[0]=0xF0 -> halted=1, cntrl stays 00, start ignored for 20 cycles.
//     clr low while imem_req=1 -> req=0 immediately.
//  6. Ack withheld: macro on -> err=1, halted=1 after 15 FETCH cycles;
//     macro off -> imem_req still 1 after 100 cycles.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: instruction-memory fetch bus between sequencer and memory.
// master = sequencer side, slave = memory side.
interface pc_sequencer_if #(
  parameter int ADDR_W  = 4,
  parameter int INSTR_W = 8
);
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_data;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_data
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_data
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/decode controller driving the PC's cntrl/loadIn port.
// Optional fetch-wait timeout: define PCSEQ_FETCH_TIMEOUT_EN.
module pc_sequencer #(
  parameter int ADDR_W  = 4,
  parameter int INSTR_W = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [ADDR_W-1:0] pc,
  input  logic              zflag,
  pc_sequencer_if.master    imem,
  output logic [1:0]        cntrl,
  output logic [ADDR_W-1:0] loadIn,
  output logic              busy,
  output logic              halted,
  output logic              err
);

  localparam logic [3:0] OP_JMP  = 4'h1;
  localparam logic [3:0] OP_SKIP = 4'h2;
  localparam logic [3:0] OP_BZ   = 4'h3;
  localparam logic [3:0] OP_SPIN = 4'h4;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] PC_HOLD = 2'b00;
  localparam logic [1:0] PC_LOAD = 2'b01;
  localparam logic [1:0] PC_INC1 = 2'b10;
  localparam logic [1:0] PC_INC2 = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_UPD,
    S_HALT
  } state_t;

  state_t            state;
  logic [3:0]        ir_op;
  logic [3:0]        op_d;
  logic [ADDR_W-1:0] arg_d;
  logic [1:0]        cntrl_d;
  logic              to_hit;

  assign imem.imem_addr = pc;
  assign op_d  = imem.imem_data[INSTR_W-1 -: 4];
  assign arg_d = imem.imem_data[ADDR_W-1:0];

  // Decoded straight off the bus so cntrl is valid for the whole UPD cycle.
  always_comb begin
    cntrl_d = PC_INC1;
    unique case (1'b1)
      op_d == OP_JMP:  cntrl_d = PC_LOAD;
      op_d == OP_SKIP: cntrl_d = PC_INC2;
      op_d == OP_BZ:   cntrl_d = zflag ? PC_LOAD : PC_INC1;
      op_d == OP_SPIN,
      op_d == OP_HALT: cntrl_d = PC_HOLD;
      default:         cntrl_d = PC_INC1;
    endcase
  end

`ifdef PCSEQ_FETCH_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      to_cnt <= '0;
    end else if (state != S_FETCH || imem.imem_ack) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign to_hit = (state == S_FETCH) && !imem.imem_ack &&
                  (to_cnt == TO_W'(TIMEOUT - 1));
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state         <= S_IDLE;
      imem.imem_req <= 1'b0;
      cntrl         <= PC_HOLD;
      loadIn        <= '0;
      busy          <= 1'b0;
      halted        <= 1'b0;
      err           <= 1'b0;
      ir_op         <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          cntrl <= PC_HOLD;
          if (start) begin
            state         <= S_FETCH;
            imem.imem_req <= 1'b1;
            busy          <= 1'b1;
          end
        end
        S_FETCH: begin
          cntrl <= PC_HOLD;
          if (imem.imem_ack) begin
            state         <= S_UPD;
            imem.imem_req <= 1'b0;
            ir_op         <= op_d;
            cntrl         <= cntrl_d;
            if (cntrl_d == PC_LOAD) begin
              loadIn <= arg_d;
            end
          end else if (to_hit) begin
            state         <= S_HALT;
            imem.imem_req <= 1'b0;
            busy          <= 1'b0;
            halted        <= 1'b1;
            err           <= 1'b1;
          end
        end
        S_UPD: begin
          cntrl <= PC_HOLD;
          if (ir_op == OP_HALT) begin
            state  <= S_HALT;
            busy   <= 1'b0;
            halted <= 1'b1;
          end else begin
            state         <= S_FETCH;
            imem.imem_req <= 1'b1;
          end
        end
        S_HALT: begin
          cntrl         <= PC_HOLD;
          imem.imem_req <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
